// File: rtl/viterbi_pkg.sv
// Shared types and constants for the channel model between the convolutional
// encoder and the Viterbi decoder.
package viterbi_pkg;

  typedef logic [1:0] sym_t;

  typedef enum logic [1:0] {
    CH_CLEAN  = 2'd0,
    CH_BURST  = 2'd1,
    CH_RANDOM = 2'd2,
    CH_RSVD   = 2'd3
  } chan_mode_e;

  // Fibonacci taps 16,14,13,11 as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [1:0] popcount2(sym_t m);
    return {1'b0, m[0]} + {1'b0, m[1]};
  endfunction

endpackage

// File: rtl/chan_lfsr16.sv
// 16-bit Fibonacci LFSR that steps once per asserted advance_i.
module chan_lfsr16
  import viterbi_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        advance_i,
  output logic [15:0] state_o
);

  logic [15:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (advance_i) state_d = {state_q[14:0], ^(state_q & LFSR_TAPS)};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= SEED;
    else      state_q <= state_d;
  end

  assign state_o = state_q;

endmodule

// File: rtl/viterbi_channel.sv
// Channel model: registers each encoded symbol and injects burst or pseudo-random
// errors inside a window after reset, counting symbols and flipped bits.
module viterbi_channel
  import viterbi_pkg::*;
#(
  parameter int unsigned N         = 4,
  parameter int unsigned BURST_LEN = 2,
  parameter int unsigned WINDOW    = 256,
  parameter sym_t        ERR_MASK  = 2'b10,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  mode_i,
  input  logic        enable_i,
  input  logic [1:0]  d_in,
  output logic        valid_o,
  output logic [1:0]  d_out,
  output logic [1:0]  err_inj_o,
  output logic [15:0] sym_ct_o,
  output logic [15:0] err_ct_o,
  output logic [15:0] bad_bit_ct_o
);

  localparam int unsigned Period     = 1 << N;
  localparam logic [N-1:0] BurstStart = N'(Period - BURST_LEN);

  logic [15:0] lfsr;
  logic        unused_lfsr;
  chan_mode_e  mode;
  logic        in_window, hit;
  sym_t        mask;
  logic [16:0] bad_sum;

  logic        valid_q;
  sym_t        dout_q, inj_q;
  logic [15:0] sym_ct_q, err_ct_q, bad_ct_q;
  logic [15:0] sym_ct_d, err_ct_d, bad_ct_d;

  chan_lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk       (clk),
    .rst       (rst),
    .advance_i (enable_i),
    .state_o   (lfsr)
  );

  // Only the low N bits feed the random-mode compare
  assign unused_lfsr = ^lfsr;
  assign mode        = chan_mode_e'(mode_i);
  assign in_window   = {16'd0, sym_ct_q} < WINDOW;

  always_comb begin
    hit = 1'b0;
    case (mode)
      CH_BURST:  hit = in_window && (sym_ct_q[N-1:0] >= BurstStart);
      CH_RANDOM: hit = in_window && (lfsr[N-1:0] == '0);
      default:   hit = 1'b0;
    endcase
  end

  assign mask = hit ? ERR_MASK : 2'b00;

  always_comb begin
    sym_ct_d = (sym_ct_q == 16'hFFFF) ? sym_ct_q : sym_ct_q + 16'd1;
    err_ct_d = err_ct_q;
    if (hit && err_ct_q != 16'hFFFF) err_ct_d = err_ct_q + 16'd1;
    bad_sum  = {1'b0, bad_ct_q} + {15'd0, popcount2(mask)};
    bad_ct_d = bad_sum[16] ? 16'hFFFF : bad_sum[15:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q  <= 1'b0;
      dout_q   <= 2'b00;
      inj_q    <= 2'b00;
      sym_ct_q <= 16'd0;
      err_ct_q <= 16'd0;
      bad_ct_q <= 16'd0;
    end else begin
      valid_q <= enable_i;
      if (enable_i) begin
        dout_q   <= d_in ^ mask;
        inj_q    <= mask;
        sym_ct_q <= sym_ct_d;
        err_ct_q <= err_ct_d;
        bad_ct_q <= bad_ct_d;
      end
    end
  end

  assign valid_o      = valid_q;
  assign d_out        = dout_q;
  assign err_inj_o    = inj_q;
  assign sym_ct_o     = sym_ct_q;
  assign err_ct_o     = err_ct_q;
  assign bad_bit_ct_o = bad_ct_q;

endmodule

// File: tb/tb_viterbi_channel.sv
// Self-checking bench for viterbi_channel: constant vector table, directed
// sequences and randomized traffic against a behavioural reference model.
module tb_viterbi_channel;

  localparam int P  = 16;  // 2**N
  localparam int BL = 2;
  localparam int WIN = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  mode_i = 2'd0;
  logic        enable_i = 1'b0;
  logic [1:0]  d_in = 2'd0;
  logic        valid_o, valid3;
  logic [1:0]  d_out, d_out3, err_inj_o, inj3;
  logic [15:0] sym_ct_o, err_ct_o, bad_bit_ct_o, sym3, err3, bad3;

  always #5 clk = ~clk;

  viterbi_channel dut (
    .clk          (clk),
    .rst          (rst),
    .mode_i       (mode_i),
    .enable_i     (enable_i),
    .d_in         (d_in),
    .valid_o      (valid_o),
    .d_out        (d_out),
    .err_inj_o    (err_inj_o),
    .sym_ct_o     (sym_ct_o),
    .err_ct_o     (err_ct_o),
    .bad_bit_ct_o (bad_bit_ct_o)
  );

  viterbi_channel #(
    .ERR_MASK (2'b11)
  ) dut3 (
    .clk          (clk),
    .rst          (rst),
    .mode_i       (mode_i),
    .enable_i     (enable_i),
    .d_in         (d_in),
    .valid_o      (valid3),
    .d_out        (d_out3),
    .err_inj_o    (inj3),
    .sym_ct_o     (sym3),
    .err_ct_o     (err3),
    .bad_bit_ct_o (bad3)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model, built from the channel's rules
  int          m_k, m_err, m_bad;
  logic [15:0] m_lfsr;
  logic [1:0]  m_dout, m_inj;
  logic        m_valid;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    int   taps [4] = '{16, 14, 13, 11};
    logic fb = 1'b0;
    foreach (taps[i]) fb ^= s[taps[i]-1];
    return {s[14:0], fb};
  endfunction

  function automatic bit model_hit(input int k, input logic [1:0] mode, input logic [15:0] l);
    if (k >= WIN) return 1'b0;
    if (mode == 2'd1) return (k % P) >= (P - BL);
    if (mode == 2'd2) return (int'(l) % P) == 0;
    return 1'b0;
  endfunction

  function automatic int sat(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic model_reset();
    m_k = 0; m_err = 0; m_bad = 0;
    m_lfsr = 16'hACE1;
    m_dout = 2'b00; m_inj = 2'b00; m_valid = 1'b0;
  endtask

  task automatic step(input logic en, input logic [1:0] d, input logic [1:0] mode);
    bit h;
    enable_i = en; d_in = d; mode_i = mode;
    if (en) begin
      h      = model_hit(m_k, mode, m_lfsr);
      m_inj  = h ? 2'b10 : 2'b00;
      m_dout = d ^ m_inj;
      m_err += int'(h);
      m_bad += int'(h);
      m_k++;
      m_lfsr = lfsr_next(m_lfsr);
    end
    m_valid = en;
    @(posedge clk); #1;
    check($sformatf("valid k=%0d", m_k), 32'(valid_o), 32'(m_valid));
    check($sformatf("d_out k=%0d", m_k), 32'(d_out), 32'(m_dout));
    check($sformatf("err_inj k=%0d", m_k), 32'(err_inj_o), 32'(m_inj));
    check($sformatf("sym_ct k=%0d", m_k), 32'(sym_ct_o), 32'(sat(m_k)));
    check($sformatf("err_ct k=%0d", m_k), 32'(err_ct_o), 32'(sat(m_err)));
    check($sformatf("bad_ct k=%0d", m_k), 32'(bad_bit_ct_o), 32'(sat(m_bad)));
  endtask

  task automatic check_zero(input string tag);
    check({tag, " valid"}, 32'(valid_o), 32'd0);
    check({tag, " d_out"}, 32'(d_out), 32'd0);
    check({tag, " err_inj"}, 32'(err_inj_o), 32'd0);
    check({tag, " sym_ct"}, 32'(sym_ct_o), 32'd0);
    check({tag, " err_ct"}, 32'(err_ct_o), 32'd0);
    check({tag, " bad_ct"}, 32'(bad_bit_ct_o), 32'd0);
  endtask

  task automatic do_reset();
    enable_i = 1'b0;
    rst = 1'b0;
    #1;
    check_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic [1:0] mode;
    logic       en;
    logic [1:0] d;
    logic       exp_valid;
    logic [1:0] exp_dout;
    logic [1:0] exp_inj;
  } vec_t;

  vec_t tbl[$];

  initial begin
    // Mode-1 vectors with expected outputs worked out by hand
    tbl.push_back('{2'd1, 1'b1, 2'b01, 1'b1, 2'b01, 2'b00});  // k0
    tbl.push_back('{2'd1, 1'b0, 2'b11, 1'b0, 2'b01, 2'b00});  // idle holds
    tbl.push_back('{2'd1, 1'b1, 2'b10, 1'b1, 2'b10, 2'b00});  // k1
    for (int k = 2; k < 14; k++) tbl.push_back('{2'd1, 1'b1, 2'b11, 1'b1, 2'b11, 2'b00});
    tbl.push_back('{2'd1, 1'b1, 2'b01, 1'b1, 2'b11, 2'b10});  // k14 hit
    tbl.push_back('{2'd1, 1'b0, 2'b00, 1'b0, 2'b11, 2'b10});  // idle holds corrupted
    tbl.push_back('{2'd1, 1'b1, 2'b11, 1'b1, 2'b01, 2'b10});  // k15 hit
    tbl.push_back('{2'd0, 1'b1, 2'b10, 1'b1, 2'b10, 2'b00});  // k16 clean
    tbl.push_back('{2'd1, 1'b1, 2'b00, 1'b1, 2'b00, 2'b00});  // k17 outside burst

    do_reset();
    foreach (tbl[i]) begin
      enable_i = tbl[i].en; d_in = tbl[i].d; mode_i = tbl[i].mode;
      @(posedge clk); #1;
      check($sformatf("tbl%0d valid", i), 32'(valid_o), 32'(tbl[i].exp_valid));
      check($sformatf("tbl%0d d_out", i), 32'(d_out), 32'(tbl[i].exp_dout));
      check($sformatf("tbl%0d err_inj", i), 32'(err_inj_o), 32'(tbl[i].exp_inj));
    end
    check("tbl sym_ct", 32'(sym_ct_o), 32'd18);
    check("tbl err_ct", 32'(err_ct_o), 32'd2);

    // 1: clean stream
    do_reset();
    for (int i = 0; i < 300; i++) step(1'b1, 2'b01, 2'd0);
    check("t1 sym_ct", 32'(sym_ct_o), 32'd300);
    check("t1 err_ct", 32'(err_ct_o), 32'd0);
    check("t1 bad_ct", 32'(bad_bit_ct_o), 32'd0);

    // 2: periodic burst across the window end
    do_reset();
    for (int i = 0; i < 300; i++) step(1'b1, 2'b00, 2'd1);
    check("t2 err_ct", 32'(err_ct_o), 32'd32);
    check("t2 bad_ct", 32'(bad_bit_ct_o), 32'd32);

    // 3: enable toggling
    do_reset();
    for (int i = 0; i < 64; i++) step(~i[0], 2'b00, 2'd1);
    check("t3 sym_ct", 32'(sym_ct_o), 32'd32);
    check("t3 err_ct", 32'(err_ct_o), 32'd4);

    // 4: random mode from seed
    do_reset();
    for (int i = 0; i < 256; i++) step(1'b1, 2'($urandom_range(0, 3)), 2'd2);
    check("t4 err_ct in range", 32'(err_ct_o >= 4 && err_ct_o <= 40), 32'd1);

    // 5: full mask, then mode switch at k=20
    do_reset();
    for (int i = 0; i < 32; i++) step(1'b1, 2'b00, 2'd1);
    check("t5 mask3 err_ct", 32'(err3), 32'd4);
    check("t5 mask3 bad_ct", 32'(bad3), 32'd8);
    do_reset();
    for (int i = 0; i < 32; i++) begin
      step(1'b1, 2'b01, (i < 20) ? 2'd1 : 2'd0);
      if (i >= 20) check($sformatf("t5 mask3 inj k=%0d", i), 32'(inj3), 32'd0);
    end
    check("t5 switch err_ct", 32'(err3), 32'd2);
    check("t5 switch bad_ct", 32'(bad3), 32'd4);

    // 6: reset mid-burst, then random mode repeats from seed
    do_reset();
    for (int i = 0; i < 111; i++) step(1'b1, 2'b00, 2'd1);
    check("t6 corrupted before reset", 32'(err_inj_o), 32'h2);
    rst = 1'b0;
    #1;
    check_zero("t6 async");
    @(posedge clk); #1;
    check_zero("t6 held");
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 40; i++) step(1'b1, 2'b11, 2'd2);

    // Randomized traffic: mode, enable and data all vary per cycle
    do_reset();
    for (int i = 0; i < 500; i++)
      step(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
